aes_round_key_store: RTL and testbench
======================================

// Module: aes_round_key_store
// PURPOSE
//  Round-key buffer between the key-expansion datapath (writer) and the AES round controller (reader).
//  Expansion writes one round key per round index. The controller reads keys back by round number:
//  forward order for encipher, reverse order (last..0) for decipher.
//  Lets decipher rounds run after a single key-schedule pass. Tracks completeness per mode.
// PARAMETERS
//  KEY_W       128  width of one round key in bits
//  MAX_KEYS    15   storage depth; key indices 0..14 (AES256 worst case)
// PORTS
//  clk           in   1      system clock, rising edge
//  reset_n       in   1      asynchronous active-low reset
//  mode          in   2      00=AES128 (11 keys), 01=AES192 (13), 10=AES256 (15), 11=reserved; sampled on load_start
//  load_start    in   1      1-cycle pulse; begin a new key-schedule capture
//  wr_en         in   1      write strobe from key expansion
//  wr_round      in   4      key index being written
//  wr_key        in   KEY_W  round key data
//  rd_req        in   1      read strobe from round controller
//  rd_round      in   4      round number requested
//  rd_dec        in   1      1 = decipher indexing (physical = last_idx - rd_round)
//  rd_key        out  KEY_W  registered read data
//  rd_valid      out  1      rd_key valid, exactly 1 cycle after an accepted rd_req
//  sched_ready   out  1      all keys for latched mode written
//  busy          out  1      capture or zeroize in progress
//  err           out  1      sticky: bad write/read index, read while not ready, or mode 11; cleared by load_start
// BEHAVIOUR
//  Reset (async): state=IDLE; rd_key=0, rd_valid=0, sched_ready=0, busy=0, err=0; valid bitmap=0; mode_q=00.
//  last_idx = 10/12/14 for mode_q 00/01/10.
//  States IDLE, LOAD, READY (plus CLEAR when the zeroize option is compiled in).
//  IDLE  --load_start--> LOAD; mode_q<=mode; bitmap<=0; err<=0; busy<=1.
//  LOAD: wr_en with wr_round<=last_idx -> store word, set bitmap bit (overwrite allowed, count unchanged).
//  LOAD: wr_round>last_idx -> write dropped, err<=1.
//  LOAD --> READY the cycle after bitmap bits 0..last_idx are all 1. Then sched_ready<=1, busy<=0.
//  READY: rd_req with rd_round<=last_idx -> rd_key<=mem[idx] next cycle, rd_valid<=1 for 1 cycle.
//    idx = rd_dec ? last_idx-rd_round : rd_round.
//  rd_req when not READY, or rd_round>last_idx: rd_valid<=1, rd_key<=0, err<=1. Bench sees a response and can flag it.
//  Back-to-back rd_req every cycle is supported (full throughput, 1-cycle latency).
//  wr_en in READY or IDLE: ignored, no err.
//  load_start in any state restarts LOAD. It has priority over a same-cycle wr_en or rd_req.
//  Same-cycle rd_req is dropped, with no rd_valid. sched_ready drops the cycle after load_start.
//  mode=11 at load_start: mode_q<=10 (AES256 indexing), err<=1.
//  mode input changes outside load_start: no effect.
//  reset_n low mid-operation: immediate return to reset values. Memory contents undefined but unreadable (bitmap=0).
// CONFIGURATION
//  AES_KEY_STORE_ZEROIZE_EN defined:
//    load_start enters CLEAR. CLEAR writes 0 to one entry per cycle, entries 0..MAX_KEYS-1 (15 cycles), busy=1.
//    CLEAR then goes to LOAD. wr_en during CLEAR is dropped and sets err.
//  AES_KEY_STORE_ZEROIZE_EN undefined: no CLEAR state. Only the bitmap is cleared; stale keys remain in RAM.
// TESTING
//  T1: mode=00, load_start, write idx 0..10 with key=idx*0x0101... -> sched_ready high 1 cycle after idx 10;
//      rd_round=3, rd_dec=0 -> rd_key=idx 3 pattern at +1 cycle.
//  T2: mode=10 loaded; rd_dec=1, rd_round 0..14 back-to-back -> rd_key sequence idx 14..0, rd_valid high 15 cycles.
//  T3: mode=01; wr_round=13 -> dropped, err=1; sched_ready after idx 0..12; rd_round=13 -> rd_key=0, err held.
//  T4: rd_req during LOAD -> rd_valid=1, rd_key=0, err=1; load_start -> err=0, sched_ready=0 next cycle.
//  T5: reset_n asserted mid-LOAD, async (no clock) -> all outputs 0 immediately; rd_req after release -> err=1.
//  T6 (ZEROIZE_EN): after full load, load_start -> busy high 15 cycles, then LOAD; rd of any idx after reload only returns new data.

Source files
------------

// File: rtl/aes_round_key_store_if.sv
// Bus bundle between key expansion/round controller (master) and the round-key store (slave).
interface aes_round_key_store_if #(
    parameter int KEY_W = 128
);
    logic [1:0]       mode;
    logic             load_start;
    logic             wr_en;
    logic [3:0]       wr_round;
    logic [KEY_W-1:0] wr_key;
    logic             rd_req;
    logic [3:0]       rd_round;
    logic             rd_dec;
    logic [KEY_W-1:0] rd_key;
    logic             rd_valid;
    logic             sched_ready;
    logic             busy;
    logic             err;

    modport master (
        output mode, load_start, wr_en, wr_round, wr_key, rd_req, rd_round, rd_dec,
        input  rd_key, rd_valid, sched_ready, busy, err
    );

    modport slave (
        input  mode, load_start, wr_en, wr_round, wr_key, rd_req, rd_round, rd_dec,
        output rd_key, rd_valid, sched_ready, busy, err
    );
endinterface

// File: rtl/aes_round_key_store.sv
// Round-key buffer: captures one key-schedule pass, serves forward or reverse-ordered reads.
// Optional AES_KEY_STORE_ZEROIZE_EN wipes every entry before each new capture.
module aes_round_key_store #(
    parameter int KEY_W    = 128,
    parameter int MAX_KEYS = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    aes_round_key_store_if.slave  bus
);

`ifdef AES_KEY_STORE_ZEROIZE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READY = 2'd2, CLEAR = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READY = 2'd2} state_t;
`endif

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [MAX_KEYS-1:0]   bitmap_q, bitmap_d;
    logic [KEY_W-1:0]      rd_key_q, rd_key_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  sched_ready_q, sched_ready_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [KEY_W-1:0]      mem_q [MAX_KEYS];
    logic                  mem_we_d;
    logic [3:0]            mem_addr_d;
    logic [KEY_W-1:0]      mem_wdata_d;
`ifdef AES_KEY_STORE_ZEROIZE_EN
    logic [3:0]            clr_cnt_q, clr_cnt_d;
`endif

    logic [3:0]            last_idx_s;
    logic [MAX_KEYS-1:0]   full_mask_s;
    logic                  sched_full_s;
    logic [3:0]            rd_idx_s;
    logic                  rd_ok_s;

    // Highest key index and required bitmap for the latched key size
    always_comb begin
        case (mode_q)
            2'b00: begin
                last_idx_s  = 4'd10;
                full_mask_s = MAX_KEYS'(15'h07FF);
            end
            2'b01: begin
                last_idx_s  = 4'd12;
                full_mask_s = MAX_KEYS'(15'h1FFF);
            end
            default: begin
                last_idx_s  = 4'd14;
                full_mask_s = MAX_KEYS'(15'h7FFF);
            end
        endcase
    end

    // Physical read index: decipher walks the schedule from the last key down
    always_comb begin
        if (bus.rd_dec) begin
            rd_idx_s = last_idx_s - bus.rd_round;
        end else begin
            rd_idx_s = bus.rd_round;
        end
    end

    assign sched_full_s = ((bitmap_q & full_mask_s) == full_mask_s);
    assign rd_ok_s      = (state_q == READY) && (bus.rd_round <= last_idx_s);

    // Next-state, capture and read-response logic
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        bitmap_d      = bitmap_q;
        rd_key_d      = rd_key_q;
        rd_valid_d    = 1'b0;
        sched_ready_d = sched_ready_q;
        busy_d        = busy_q;
        err_d         = err_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = bus.wr_round;
        mem_wdata_d   = bus.wr_key;
`ifdef AES_KEY_STORE_ZEROIZE_EN
        clr_cnt_d     = clr_cnt_q;
`endif
        if (bus.load_start) begin
            // Reserved size falls back to the deepest schedule but is flagged
            if (bus.mode == 2'b11) begin
                mode_d = 2'b10;
                err_d  = 1'b1;
            end else begin
                mode_d = bus.mode;
                err_d  = 1'b0;
            end
            bitmap_d      = '0;
            sched_ready_d = 1'b0;
            busy_d        = 1'b1;
`ifdef AES_KEY_STORE_ZEROIZE_EN
            state_d       = CLEAR;
            clr_cnt_d     = 4'd0;
`else
            state_d       = LOAD;
`endif
        end else begin
            if (bus.rd_req) begin
                rd_valid_d = 1'b1;
                if (rd_ok_s) begin
                    rd_key_d = mem_q[rd_idx_s];
                end else begin
                    rd_key_d = '0;
                    err_d    = 1'b1;
                end
            end else begin
                rd_valid_d = 1'b0;
            end

            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                LOAD: begin
                    if (bus.wr_en) begin
                        if (bus.wr_round <= last_idx_s) begin
                            mem_we_d               = 1'b1;
                            bitmap_d[bus.wr_round] = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        mem_we_d = 1'b0;
                    end
                    if (sched_full_s) begin
                        state_d       = READY;
                        sched_ready_d = 1'b1;
                        busy_d        = 1'b0;
                    end else begin
                        state_d = LOAD;
                    end
                end
                READY: begin
                    state_d = READY;
                end
`ifdef AES_KEY_STORE_ZEROIZE_EN
                CLEAR: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = clr_cnt_q;
                    mem_wdata_d = '0;
                    if (bus.wr_en) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (clr_cnt_q == 4'(MAX_KEYS - 1)) begin
                        state_d   = LOAD;
                        clr_cnt_d = 4'd0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 4'd1;
                    end
                end
`endif
                default: begin
                    state_d       = IDLE;
                    sched_ready_d = 1'b0;
                    busy_d        = 1'b0;
                end
            endcase
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            mode_q        <= 2'b00;
            bitmap_q      <= '0;
            rd_key_q      <= '0;
            rd_valid_q    <= 1'b0;
            sched_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
`ifdef AES_KEY_STORE_ZEROIZE_EN
            clr_cnt_q     <= 4'd0;
`endif
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            bitmap_q      <= bitmap_d;
            rd_key_q      <= rd_key_d;
            rd_valid_q    <= rd_valid_d;
            sched_ready_q <= sched_ready_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
`ifdef AES_KEY_STORE_ZEROIZE_EN
            clr_cnt_q     <= clr_cnt_d;
`endif
        end
    end

    // Key storage; unreset because the bitmap gates every read
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_addr_d] <= mem_wdata_d;
        end
    end

    assign bus.rd_key      = rd_key_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.sched_ready = sched_ready_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_aes_round_key_store.sv
// Directed self-checking bench for aes_round_key_store (default and zeroize builds).
module tb_aes_round_key_store;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    aes_round_key_store_if #(.KEY_W(128)) bus ();

    aes_round_key_store #(.KEY_W(128), .MAX_KEYS(15)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] key_of(input int idx, input logic [7:0] x);
        logic [127:0] k;
        for (int b = 0; b < 16; b++) k[8*b +: 8] = 8'(idx) ^ x;
        return k;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [1:0] m);
        bus.mode       = m;
        bus.load_start = 1'b1;
        cyc();
        bus.load_start = 1'b0;
        chk("load_busy", 128'(bus.busy), 128'(1));
        chk("load_sched_drop", 128'(bus.sched_ready), 128'(0));
`ifdef AES_KEY_STORE_ZEROIZE_EN
        for (int i = 0; i < 15; i++) begin
            cyc();
            chk("clear_busy", 128'(bus.busy), 128'(1));
        end
`endif
    endtask

    task automatic write_keys(input int first, input int last, input logic [7:0] x);
        for (int i = first; i <= last; i++) begin
            bus.wr_en    = 1'b1;
            bus.wr_round = 4'(i);
            bus.wr_key   = key_of(i, x);
            cyc();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic read1(input int r, input logic d);
        bus.rd_req   = 1'b1;
        bus.rd_round = 4'(r);
        bus.rd_dec   = d;
        cyc();
        bus.rd_req   = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        bus.mode       = 2'b00;
        bus.load_start = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_round   = 4'd0;
        bus.wr_key     = 128'd0;
        bus.rd_req     = 1'b0;
        bus.rd_round   = 4'd0;
        bus.rd_dec     = 1'b0;
        reset_n        = 1'b1;
        #2 reset_n = 1'b0;
        #2;
        chk("rst_rd_key", bus.rd_key, 128'd0);
        chk("rst_rd_valid", 128'(bus.rd_valid), 128'(0));
        chk("rst_sched_ready", 128'(bus.sched_ready), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_err", 128'(bus.err), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();

        // T1: AES128 forward capture and read
        start_load(2'b00);
        write_keys(0, 10, 8'h00);
        chk("t1_ready_not_yet", 128'(bus.sched_ready), 128'(0));
        cyc();
        chk("t1_sched_ready", 128'(bus.sched_ready), 128'(1));
        chk("t1_busy_low", 128'(bus.busy), 128'(0));
        read1(3, 1'b0);
        chk("t1_rd_valid", 128'(bus.rd_valid), 128'(1));
        chk("t1_rd_key3", bus.rd_key, key_of(3, 8'h00));
        chk("t1_err", 128'(bus.err), 128'(0));
        cyc();
        chk("t1_rd_valid_pulse", 128'(bus.rd_valid), 128'(0));
        write_keys(3, 3, 8'hFF);
        chk("t1_wr_ready_no_err", 128'(bus.err), 128'(0));
        read1(0, 1'b1);
        chk("t1_dec0_key10", bus.rd_key, key_of(10, 8'h00));
        read1(3, 1'b0);
        chk("t1_wr_ready_ignored", bus.rd_key, key_of(3, 8'h00));

        // T2: AES256 reverse back-to-back reads
        start_load(2'b10);
        write_keys(0, 14, 8'h30);
        cyc();
        chk("t2_sched_ready", 128'(bus.sched_ready), 128'(1));
        bus.mode = 2'b00;
        for (int r = 0; r < 15; r++) begin
            bus.rd_req   = 1'b1;
            bus.rd_round = 4'(r);
            bus.rd_dec   = 1'b1;
            cyc();
            chk("t2_rd_valid", 128'(bus.rd_valid), 128'(1));
            chk("t2_rd_key", bus.rd_key, key_of(14 - r, 8'h30));
        end
        bus.rd_req = 1'b0;
        chk("t2_err", 128'(bus.err), 128'(0));
        cyc();
        chk("t2_rd_valid_end", 128'(bus.rd_valid), 128'(0));

        // T3: AES192 out-of-range write and read
        start_load(2'b01);
        write_keys(13, 13, 8'h55);
        chk("t3_bad_wr_err", 128'(bus.err), 128'(1));
        write_keys(0, 12, 8'h60);
        cyc();
        chk("t3_sched_ready", 128'(bus.sched_ready), 128'(1));
        read1(12, 1'b1);
        chk("t3_dec12_key0", bus.rd_key, key_of(0, 8'h60));
        read1(13, 1'b0);
        chk("t3_bad_rd_valid", 128'(bus.rd_valid), 128'(1));
        chk("t3_bad_rd_key", bus.rd_key, 128'd0);
        chk("t3_err_held", 128'(bus.err), 128'(1));

        // T4: read during capture, load_start priority, reserved mode
        start_load(2'b00);
        chk("t4_err_cleared", 128'(bus.err), 128'(0));
        read1(2, 1'b0);
        chk("t4_load_rd_valid", 128'(bus.rd_valid), 128'(1));
        chk("t4_load_rd_key", bus.rd_key, 128'd0);
        chk("t4_load_rd_err", 128'(bus.err), 128'(1));
        bus.rd_req = 1'b1;
        start_load(2'b11);
        bus.rd_req = 1'b0;
        chk("t4_rd_dropped", 128'(bus.rd_valid), 128'(0));
        chk("t4_mode11_err", 128'(bus.err), 128'(1));
        write_keys(0, 13, 8'h70);
        cyc();
        chk("t4_mode11_not_ready", 128'(bus.sched_ready), 128'(0));
        write_keys(14, 14, 8'h70);
        cyc();
        chk("t4_mode11_ready", 128'(bus.sched_ready), 128'(1));
        read1(14, 1'b0);
        chk("t4_mode11_key14", bus.rd_key, key_of(14, 8'h70));

        // T5: asynchronous reset in the middle of a capture
        start_load(2'b00);
        write_keys(0, 4, 8'h11);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_busy", 128'(bus.busy), 128'(0));
        chk("t5_rst_err", 128'(bus.err), 128'(0));
        chk("t5_rst_sched", 128'(bus.sched_ready), 128'(0));
        chk("t5_rst_rd_key", bus.rd_key, 128'd0);
        chk("t5_rst_rd_valid", 128'(bus.rd_valid), 128'(0));
        #2 reset_n = 1'b1;
        cyc();
        read1(0, 1'b0);
        chk("t5_rd_after_rst_valid", 128'(bus.rd_valid), 128'(1));
        chk("t5_rd_after_rst_key", bus.rd_key, 128'd0);
        chk("t5_rd_after_rst_err", 128'(bus.err), 128'(1));

        // T6: reload returns only the new schedule
        start_load(2'b00);
        write_keys(0, 10, 8'h21);
        cyc();
        start_load(2'b00);
        write_keys(0, 10, 8'hA5);
        cyc();
        chk("t6_sched_ready", 128'(bus.sched_ready), 128'(1));
        read1(5, 1'b0);
        chk("t6_new_key5", bus.rd_key, key_of(5, 8'hA5));
        read1(0, 1'b1);
        chk("t6_new_key10", bus.rd_key, key_of(10, 8'hA5));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
